alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle CPU ALU.
- Executes all existing logic/arithmetic ops with one cycle of latency, plus iterative unsigned multiply and divide, under a valid/ready issue handshake.
- Sits in the EX stage. The pipeline stalls on in_ready=0 and consumes results on the out_valid pulse.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- aluop  in  4  operation select
- out_valid  out  1  one-cycle pulse: result registers updated
- C  out  WIDTH  primary result
- hi  out  WIDTH  MUL high word / DIV remainder; 0 for other ops
- zero  out  1  A==B, sampled at issue
- overflow  out  1  signed overflow of ADD/SUB/INC/DEC; 0 otherwise
- div_by_zero  out  1  DIV issued with B==0

Behaviour:
- Reset: state IDLE; C, hi=0; zero, overflow, div_by_zero, out_valid=0; in_ready=1 from the first cycle after reset release.
- Issue: an operation is accepted on a rising edge where in_valid && in_ready. A, B and aluop are captured at that edge. in_valid while in_ready=0 is ignored, with no queueing.
- aluop encoding (all results WIDTH bits, arithmetic modulo 2^WIDTH):
  - 0000 SLT signed: C = (A<B signed) ? 1 : 0
  - 0001 AND; 0010 OR; 0100 XOR; 0011 NOT: C = ~A
  - 0101 ADD; 0110 SUB; 0111 INC: A+1; 1000 DEC: A-1
  - 1001 CLR: C = 0
  - 1010 SLTU: C = (A<B unsigned) ? 1 : 0
  - 1011 MULU
  - 1100 DIVU
  - 1101–1111: C = 0 (see optional feature)
- Overflow rules:
  - ADD: A and B same sign, result sign differs.
  - SUB: A and B signs differ, result sign ≠ A sign.
  - INC: A = 0x7F..F.
  - DEC: A = 0x80..0.
- Single-cycle ops: accepted at edge N; C, hi, flags and out_valid=1 are registered at edge N+1. in_ready stays 1, so back-to-back issue gives one result per cycle.
- MULU: shift-add, one bit per cycle.
  - FSM IDLE→MUL on accept; counter runs WIDTH iterations; MUL→IDLE after the last one.
  - {hi, C} = A*B (2·WIDTH-bit product).
  - out_valid at edge N+WIDTH; in_ready=0 from N through N+WIDTH-1.
- DIVU: restoring, one bit per cycle. FSM IDLE→DIV, same WIDTH latency. C = A/B, hi = A%B.
- Divide by zero (B==0): no iteration. Result at edge N+1: C = all ones, hi = A, div_by_zero=1.
- Flags (zero, overflow, div_by_zero) update together with C/hi and hold until the next result.
- out_valid is high for exactly one cycle per accepted op.
- Outputs hold their last result while busy.
- rst asserted mid-MUL/DIV: abort immediately; return to reset values; no out_valid for the aborted op.
- Operands equal to 0 or all ones need no special case beyond the rules above.

Optional Feature:
- Macro: ALU_SIGNED_MD_EN.
- Defined:
  - 1101 MUL signed: {hi, C} = two's-complement 2·WIDTH-bit product.
  - 1110 DIV signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Both reuse the unsigned iterative datapath on magnitudes and fix signs on the final cycle, so latency matches MULU/DIVU.
  - Signed divide by zero behaves as DIVU.
  - MIN/-1 gives C = MIN, hi = 0, overflow = 1.
- Undefined: 1101 and 1110 behave as 1111 (C = 0, single cycle).

Test Plan:
- Reset held 3 cycles, then released → C=0, hi=0, all flags 0, in_ready=1, out_valid=0.
- Back-to-back ADD 0x7FFFFFFF+1, then SUB 5-7, then SLT 0xFFFFFFFF<1 → three consecutive out_valid pulses:
  - C=0x80000000, overflow=1
  - C=0xFFFFFFFE, overflow=0
  - C=1
- MULU A=0xFFFFFFFF, B=0xFFFFFFFF → in_ready low 32 cycles; out_valid at N+32; hi=0xFFFFFFFE, C=0x00000001.
- DIVU A=100, B=7 → C=14, hi=2 at N+32. DIVU A=5, B=0 → at N+1: C=0xFFFFFFFF, hi=5, div_by_zero=1.
- in_valid held high during MULU busy with aluop=ADD → ADD accepted only after MUL completes; exactly two out_valid pulses.
- rst pulsed at iteration 10 of DIVU → no out_valid; outputs 0 next cycle; a new ADD 2+3 then yields C=5.

Source files
------------

// File: rtl/alu_seq.sv
// Registered EX-stage ALU: single-cycle logic/arith ops plus iterative MULU/DIVU under a valid/ready handshake.
// Optional signed MUL/DIV (aluop 1101/1110) is enabled by defining ALU_SIGNED_MD_EN.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       aluop,
  output logic             out_valid,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [3:0] OP_SLT  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_INC  = 4'b0111;
  localparam logic [3:0] OP_DEC  = 4'b1000;
  localparam logic [3:0] OP_CLR  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_MULS = 4'b1101;
  localparam logic [3:0] OP_DIVS = 4'b1110;

  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             eq_q, eq_d, sc_q, sc_d;
  logic [WIDTH-1:0] c_q, c_d, hi_q, hi_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d, ov_q, ov_d;

  logic             md_signed_in, md_signed_q;
  logic             accept, mul_in, div_in;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic [WIDTH-1:0] add_r, sub_r;
  logic [WIDTH-1:0] sc_c, sc_hi;
  logic             sc_ovf, sc_dbz;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] acc_n, lo_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fin_c, fin_hi;
  logic             fin_ovf;

`ifdef ALU_SIGNED_MD_EN
  assign md_signed_in = (aluop == OP_MULS) || (aluop == OP_DIVS);
  assign md_signed_q  = (op_q == OP_MULS) || (op_q == OP_DIVS);
`else
  assign md_signed_in = 1'b0;
  assign md_signed_q  = 1'b0;
`endif

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign mul_in   = (aluop == OP_MULU) || (md_signed_in && aluop == OP_MULS);
  assign div_in   = ((aluop == OP_DIVU) || (md_signed_in && aluop == OP_DIVS)) && (B != '0);
  // Signed ops iterate on magnitudes; signs are restored from a_q/b_q on the last cycle.
  assign mag_a_in = (md_signed_in && A[M]) ? -A : A;
  assign mag_b_in = (md_signed_in && B[M]) ? -B : B;
  assign add_r    = a_q + b_q;
  assign sub_r    = a_q - b_q;

  always_comb begin
    sc_c   = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dbz = 1'b0;
    case (op_q)
      OP_SLT:  sc_c[0] = ($signed(a_q) < $signed(b_q));
      OP_AND:  sc_c = a_q & b_q;
      OP_OR:   sc_c = a_q | b_q;
      OP_NOT:  sc_c = ~a_q;
      OP_XOR:  sc_c = a_q ^ b_q;
      OP_ADD: begin
        sc_c   = add_r;
        sc_ovf = (a_q[M] == b_q[M]) && (add_r[M] != a_q[M]);
      end
      OP_SUB: begin
        sc_c   = sub_r;
        sc_ovf = (a_q[M] != b_q[M]) && (sub_r[M] != a_q[M]);
      end
      OP_INC: begin
        sc_c   = a_q + WIDTH'(1);
        sc_ovf = (a_q == MAX_POS);
      end
      OP_DEC: begin
        sc_c   = a_q - WIDTH'(1);
        sc_ovf = (a_q == MIN_NEG);
      end
      OP_SLTU: sc_c[0] = (a_q < b_q);
      // Only divide-by-zero reaches the single-cycle path for a divide opcode.
      OP_DIVU: begin
        sc_c   = '1;
        sc_hi  = a_q;
        sc_dbz = 1'b1;
      end
      OP_DIVS: if (md_signed_q) begin
        sc_c   = '1;
        sc_hi  = a_q;
        sc_dbz = 1'b1;
      end
      default: sc_c = '0;
    endcase
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, lo_q[M]};
    div_trial = div_shift - {1'b0, opnd_q};
    acc_n     = acc_q;
    lo_n      = lo_q;
    if (state_q == ST_MUL) begin
      acc_n = mul_sum[WIDTH:1];
      lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (state_q == ST_DIV) begin
      acc_n = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      lo_n  = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end
  end

  always_comb begin
    prod    = {acc_n, lo_n};
    fin_c   = lo_n;
    fin_hi  = acc_n;
    fin_ovf = 1'b0;
    if (state_q == ST_MUL) begin
      if (md_signed_q && (a_q[M] ^ b_q[M])) prod = -prod;
      fin_c  = prod[WIDTH-1:0];
      fin_hi = prod[2*WIDTH-1:WIDTH];
    end else if (md_signed_q) begin
      if (a_q[M] ^ b_q[M]) fin_c = -lo_n;
      if (a_q[M])          fin_hi = -acc_n;
      fin_ovf = (a_q == MIN_NEG) && (b_q == '1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    eq_d    = eq_q;
    sc_d    = 1'b0;
    c_d     = c_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    ov_d    = 1'b0;

    if (sc_q) begin
      c_d    = sc_c;
      hi_d   = sc_hi;
      zero_d = eq_q;
      ovf_d  = sc_ovf;
      dbz_d  = sc_dbz;
      ov_d   = 1'b1;
    end

    case (state_q)
      ST_IDLE: if (accept) begin
        a_d  = A;
        b_d  = B;
        op_d = aluop;
        eq_d = (A == B);
        if (mul_in) begin
          state_d = ST_MUL;
          cnt_d   = CNTW'(WIDTH - 1);
          acc_d   = '0;
          lo_d    = mag_b_in;
          opnd_d  = mag_a_in;
        end else if (div_in) begin
          state_d = ST_DIV;
          cnt_d   = CNTW'(WIDTH - 1);
          acc_d   = '0;
          lo_d    = mag_a_in;
          opnd_d  = mag_b_in;
        end else begin
          sc_d = 1'b1;
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = acc_n;
        lo_d  = lo_n;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          c_d     = fin_c;
          hi_d    = fin_hi;
          zero_d  = eq_q;
          ovf_d   = fin_ovf;
          dbz_d   = 1'b0;
          ov_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      eq_q    <= 1'b0;
      sc_q    <= 1'b0;
      c_q     <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      eq_q    <= eq_d;
      sc_q    <= sc_d;
      c_q     <= c_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      ov_q    <= ov_d;
    end
  end

  assign C           = c_q;
  assign hi          = hi_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign out_valid   = ov_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed scenarios plus randomized ops against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  aluop = '0;
  logic        out_valid;
  logic [31:0] C, hi;
  logic        zero, overflow, div_by_zero;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(32), .CNTW(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .aluop(aluop), .out_valid(out_valid), .C(C), .hi(hi),
    .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] c, output logic [31:0] h,
                       output logic z, output logic ov, output logic dz, output int lat);
    longint sa, sb, s, q, r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = '0; h = '0; ov = 1'b0; dz = 1'b0; lat = 1; z = (a == b);
    case (op)
      4'd0:  c = (sa < sb) ? 32'd1 : 32'd0;
      4'd1:  c = a & b;
      4'd2:  c = a | b;
      4'd3:  c = ~a;
      4'd4:  c = a ^ b;
      4'd5:  begin s = sa + sb; c = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd6:  begin s = sa - sb; c = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7:  begin c = a + 32'd1; ov = (sa == 64'sd2147483647); end
      4'd8:  begin c = a - 32'd1; ov = (sa == -64'sd2147483648); end
      4'd10: c = (a < b) ? 32'd1 : 32'd0;
      4'd11: begin p = longint'(a) * longint'(b); c = p[31:0]; h = p[63:32]; lat = 32; end
      4'd12: begin
        if (b == 0) begin c = '1; h = a; dz = 1'b1; end
        else begin c = a / b; h = a % b; lat = 32; end
      end
`ifdef ALU_SIGNED_MD_EN
      4'd13: begin s = sa * sb; c = s[31:0]; h = s[63:32]; lat = 32; end
      4'd14: begin
        if (b == 0) begin c = '1; h = a; dz = 1'b1; end
        else begin
          q = sa / sb; r = sa % sb;
          c = q[31:0]; h = r[31:0]; lat = 32;
          ov = (sa == -64'sd2147483648) && (sb == -64'sd1);
        end
      end
`endif
      default: c = '0;
    endcase
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] ec, eh;
    logic ez, eo, ed;
    int el, lat;
    model(op, a, b, ec, eh, ez, eo, ed, el);
    @(negedge clk);
    in_valid = 1'b1; aluop = op; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".rdy"}, 64'(in_ready), 64'(el == 1));
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; break; end
    end
    chk({tag, ".lat"}, 64'(lat), 64'(el));
    chk({tag, ".C"}, 64'(C), 64'(ec));
    chk({tag, ".hi"}, 64'(hi), 64'(eh));
    chk({tag, ".flags"}, 64'({zero, overflow, div_by_zero}), 64'({ez, eo, ed}));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int pulses, add_k, ovs;
    logic rdy_before;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.C", 64'(C), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.flags", 64'({zero, overflow, div_by_zero}), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.valid", 64'(out_valid), 64'd0);

    // back-to-back single-cycle ops
    @(negedge clk);
    in_valid = 1'b1; aluop = 4'd5; A = 32'h7FFF_FFFF; B = 32'd1;
    @(posedge clk); #1;
    aluop = 4'd6; A = 32'd5; B = 32'd7;
    @(posedge clk); #1;
    chk("b2b.add.v", 64'(out_valid), 64'd1);
    chk("b2b.add.C", 64'(C), 64'h8000_0000);
    chk("b2b.add.ov", 64'(overflow), 64'd1);
    aluop = 4'd0; A = 32'hFFFF_FFFF; B = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b.sub.v", 64'(out_valid), 64'd1);
    chk("b2b.sub.C", 64'(C), 64'hFFFF_FFFE);
    chk("b2b.sub.ov", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    chk("b2b.slt.v", 64'(out_valid), 64'd1);
    chk("b2b.slt.C", 64'(C), 64'd1);

    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max");
    run_op(4'd12, 32'd100, 32'd7, "divu_100_7");
    run_op(4'd12, 32'd5, 32'd0, "divu_dbz");

    // ADD held during MULU busy is accepted only once MULU finishes
    @(negedge clk);
    in_valid = 1'b1; aluop = 4'd11; A = 32'd6; B = 32'd9;
    @(posedge clk); #1;
    aluop = 4'd5; A = 32'd2; B = 32'd3;
    pulses = 0; add_k = 0;
    for (int k = 1; k <= 40; k++) begin
      rdy_before = in_ready;
      @(posedge clk); #1;
      if (rdy_before && in_valid) in_valid = 1'b0;
      if (out_valid) begin
        pulses++;
        if (pulses == 1) chk("hold.mul.C", 64'(C), 64'd54);
        else add_k = k;
      end
    end
    chk("hold.pulses", 64'(pulses), 64'd2);
    chk("hold.add_at", 64'(add_k), 64'd34);
    chk("hold.add.C", 64'(C), 64'd5);

    // reset aborts a DIVU mid-iteration
    @(negedge clk);
    in_valid = 1'b1; aluop = 4'd12; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.valid", 64'(out_valid), 64'd0);
    chk("abort.C", 64'(C), 64'd0);
    chk("abort.ready", 64'(in_ready), 64'd1);
    ovs = 0;
    for (int k = 0; k < 36; k++) begin
      @(posedge clk); #1;
      if (out_valid) ovs++;
    end
    chk("abort.no_valid", 64'(ovs), 64'd0);
    run_op(4'd5, 32'd2, 32'd3, "abort.add");

    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
